// File: rtl/ip_tx_arbiter.sv
// Round-robin frame arbiter feeding the IP TX block from the UDP (ch0) and ICMP (ch1) transmitters.
// Optional watchdog abort of a stalled frame is built when ARB_TIMEOUT_EN is defined.
module ip_tx_arbiter #(
    parameter int P_GAP_CYCLES = 4,
    parameter int P_TIMEOUT    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ch0_req,
    input  logic [7:0]  i_ch0_type,
    input  logic [15:0] i_ch0_len,
    output logic        o_ch0_grant,
    input  logic [7:0]  i_ch0_data,
    input  logic        i_ch0_last,
    input  logic        i_ch0_valid,
    input  logic        i_ch1_req,
    input  logic [7:0]  i_ch1_type,
    input  logic [15:0] i_ch1_len,
    output logic        o_ch1_grant,
    input  logic [7:0]  i_ch1_data,
    input  logic        i_ch1_last,
    input  logic        i_ch1_valid,
    output logic [7:0]  o_ip_type,
    output logic [7:0]  o_ip_data,
    output logic [15:0] o_ip_len,
    output logic        o_ip_last,
    output logic        o_ip_valid,
    output logic        o_busy,
    output logic        o_len_err,
    output logic [1:0]  o_dbg_state
);
    // Handshake: a requester holds req (with type/len stable) until it sees its one-cycle
    // grant; from the following cycle its valid bytes are forwarded one cycle later.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;
    localparam int GW = $clog2(P_GAP_CYCLES + 1);

    if (P_GAP_CYCLES < 1 || P_TIMEOUT < 1) begin : g_bad_params
        $error("ip_tx_arbiter: P_GAP_CYCLES and P_TIMEOUT must be at least 1");
    end

    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic          ptr_q, ptr_d;
    logic [7:0]    type_q, type_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic          pick;
    logic [7:0]    sel_data;
    logic          sel_valid, sel_last;
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT + 1);
    logic [TW-1:0] wd_q, wd_d;
`endif

    assign sel_data  = sel_q ? i_ch1_data  : i_ch0_data;
    assign sel_valid = sel_q ? i_ch1_valid : i_ch0_valid;
    assign sel_last  = sel_q ? i_ch1_last  : i_ch0_last;
    // ptr_q holds the channel served most recently; reset value 1 favours channel 0.
    assign pick = (i_ch0_req && i_ch1_req) ? ~ptr_q : i_ch1_req;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        type_d  = type_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        data_d  = 8'h00;
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_ch0_req || i_ch1_req) begin
                    sel_d   = pick;
                    type_d  = pick ? i_ch1_type : i_ch0_type;
                    len_d   = pick ? i_ch1_len  : i_ch0_len;
                    cnt_d   = 16'd0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                wd_d = '0;
`endif
                if (len_q == 16'd0) begin
                    err_d   = 1'b1;
                    ptr_d   = sel_q;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                data_d  = sel_data;
                valid_d = sel_valid;
                if (sel_valid) begin
                    cnt_d = cnt_q + 16'd1;
`ifdef ARB_TIMEOUT_EN
                    wd_d  = '0;
`endif
                    // A frame ends on the sender's last or on reaching the latched length.
                    if (sel_last || (cnt_q + 16'd1 == len_q)) begin
                        last_d  = 1'b1;
                        err_d   = !(sel_last && (cnt_q + 16'd1 == len_q));
                        ptr_d   = sel_q;
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (wd_q == TW'(P_TIMEOUT - 1)) begin
                    ptr_d   = sel_q;
                    gap_d   = '0;
                    state_d = S_GAP;
                    if (cnt_q != 16'd0) begin
                        data_d  = 8'h00;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: begin
                if (gap_q == GW'(P_GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b1;
            type_q  <= 8'h00;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            gap_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            type_q  <= type_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
`ifdef ARB_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign o_ch0_grant = (state_q == S_GRANT) && !sel_q;
    assign o_ch1_grant = (state_q == S_GRANT) &&  sel_q;
    assign o_ip_type   = type_q;
    assign o_ip_len    = len_q;
    assign o_ip_data   = data_q;
    assign o_ip_valid  = valid_q;
    assign o_ip_last   = last_q;
    assign o_len_err   = err_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_dbg_state = state_q;
endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: arbitration order, forwarding, length errors, gap and reset.
module tb_ip_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ch0_req, ch1_req, ch0_last, ch1_last, ch0_valid, ch1_valid;
    logic [7:0]  ch0_type, ch1_type, ch0_data, ch1_data;
    logic [15:0] ch0_len, ch1_len;
    logic        ch0_grant, ch1_grant, ip_last, ip_valid, busy, len_err;
    logic [7:0]  ip_type, ip_data;
    logic [15:0] ip_len;
    logic [1:0]  dbg_state;
    int          tests = 0;
    int          fails = 0;
    int          n;

    always #5 clk = ~clk;

    ip_tx_arbiter #(.P_GAP_CYCLES(4), .P_TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ch0_req(ch0_req), .i_ch0_type(ch0_type), .i_ch0_len(ch0_len), .o_ch0_grant(ch0_grant),
        .i_ch0_data(ch0_data), .i_ch0_last(ch0_last), .i_ch0_valid(ch0_valid),
        .i_ch1_req(ch1_req), .i_ch1_type(ch1_type), .i_ch1_len(ch1_len), .o_ch1_grant(ch1_grant),
        .i_ch1_data(ch1_data), .i_ch1_last(ch1_last), .i_ch1_valid(ch1_valid),
        .o_ip_type(ip_type), .o_ip_data(ip_data), .o_ip_len(ip_len), .o_ip_last(ip_last),
        .o_ip_valid(ip_valid), .o_busy(busy), .o_len_err(len_err), .o_dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic r, input logic [7:0] t, input logic [15:0] l);
        if (ch == 0) begin
            ch0_req = r; ch0_type = t; ch0_len = l;
        end else begin
            ch1_req = r; ch1_type = t; ch1_len = l;
        end
    endtask

    task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic l);
        if (ch == 0) begin
            ch0_valid = v; ch0_data = d; ch0_last = l;
        end else begin
            ch1_valid = v; ch1_data = d; ch1_last = l;
        end
    endtask

    // Waits (bounded) for channel ch's grant; returns the number of ticks waited.
    task automatic wait_grant(input int ch, output int waited);
        logic g;
        waited = 0;
        g = (ch == 0) ? ch0_grant : ch1_grant;
        while (!g && waited < 40) begin
            tick();
            waited++;
            g = (ch == 0) ? ch0_grant : ch1_grant;
        end
        chk($sformatf("grant_ch%0d", ch), {31'd0, g}, 32'd1);
        chk($sformatf("no_grant_ch%0d", 1 - ch), {31'd0, (ch == 0) ? ch1_grant : ch0_grant}, 32'd0);
    endtask

    // Called on the grant sample; streams nb bytes and checks each forwarded byte.
    task automatic stream(input int ch, input int nb, input int last_idx, input logic [7:0] base,
                          input int exp_out, input logic exp_err, input logic ends, input logic garbage);
        logic fin;
        tick();
        for (int i = 0; i < nb; i++) begin
            drive(ch, 1'b1, base + 8'(i), (i == last_idx));
            if (garbage) drive(1 - ch, i[0], 8'hEE, 1'b1);
            tick();
            fin = ends && (i == exp_out - 1);
            if (i < exp_out) begin
                chk($sformatf("data_ch%0d_b%0d", ch, i), {24'd0, ip_data}, {24'd0, base + 8'(i)});
                chk($sformatf("valid_ch%0d_b%0d", ch, i), {31'd0, ip_valid}, 32'd1);
                chk($sformatf("last_ch%0d_b%0d", ch, i), {31'd0, ip_last}, {31'd0, fin});
                chk($sformatf("err_ch%0d_b%0d", ch, i), {31'd0, len_err}, {31'd0, fin & exp_err});
            end else begin
                chk($sformatf("dropped_ch%0d_b%0d", ch, i), {31'd0, ip_valid}, 32'd0);
            end
        end
        drive(ch, 1'b0, 8'h00, 1'b0);
        if (garbage) drive(1 - ch, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 8'h00, 16'd0);
        set_req(1, 1'b0, 8'h00, 16'd0);
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (2) tick();
        chk("rst_valid", {31'd0, ip_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_len", {16'd0, ip_len}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_grants", {30'd0, ch1_grant, ch0_grant}, 32'd0);

        // Both requesting from reset, held: grants alternate 0,1,0,1 with the gap between.
        set_req(0, 1'b1, 8'h11, 16'd8);
        set_req(1, 1'b1, 8'h01, 16'd8);
        rst = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_grant(f % 2, n);
            if (f > 0) chk($sformatf("gap_ticks_f%0d", f), n, 32'd5);
            chk($sformatf("rr_len_f%0d", f), {16'd0, ip_len}, 32'd8);
            stream(f % 2, 8, 7, 8'h10 * 8'(f + 1), 8, 1'b0, 1'b1, 1'b0);
        end
        set_req(0, 1'b0, 8'h00, 16'd0);
        set_req(1, 1'b0, 8'h00, 16'd0);
        repeat (5) tick();
        chk("rr_idle", {31'd0, busy}, 32'd0);

        // ch0 normal frame, len 20, type 17; busy spans the 4-cycle gap.
        set_req(0, 1'b1, 8'd17, 16'd20);
        wait_grant(0, n);
        chk("f1_type", {24'd0, ip_type}, 32'd17);
        chk("f1_len", {16'd0, ip_len}, 32'd20);
        chk("f1_busy_grant", {31'd0, busy}, 32'd1);
        set_req(0, 1'b0, 8'h00, 16'd0);
        stream(0, 20, 19, 8'h00, 20, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("f1_busy_gap_end", {31'd0, busy}, 32'd1);
        chk("f1_gap_quiet", {30'd0, ip_valid, ip_last}, 32'd0);
        tick();
        chk("f1_busy_idle", {31'd0, busy}, 32'd0);
        chk("f1_type_hold", {24'd0, ip_type}, 32'd17);

        // ch1 streams while ch0 toggles garbage valid/last.
        set_req(1, 1'b1, 8'd1, 16'd5);
        wait_grant(1, n);
        set_req(1, 1'b0, 8'h00, 16'd0);
        stream(1, 5, 4, 8'h40, 5, 1'b0, 1'b1, 1'b1);
        repeat (4) tick();
        chk("f3_idle", {31'd0, busy}, 32'd0);

        // Early end (last on byte 6 of 10), then forced end (no last, byte 11 dropped).
        set_req(0, 1'b1, 8'd6, 16'd10);
        wait_grant(0, n);
        set_req(0, 1'b0, 8'h00, 16'd0);
        stream(0, 6, 5, 8'h50, 6, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        set_req(0, 1'b1, 8'd6, 16'd10);
        wait_grant(0, n);
        set_req(0, 1'b0, 8'h00, 16'd0);
        stream(0, 11, -1, 8'h60, 10, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        chk("f4_idle", {31'd0, busy}, 32'd0);

        // len = 0: straight to GAP with an error pulse and no byte.
        set_req(1, 1'b1, 8'd1, 16'd0);
        wait_grant(1, n);
        set_req(1, 1'b0, 8'h00, 16'd0);
        tick();
        chk("len0_err", {31'd0, len_err}, 32'd1);
        chk("len0_valid", {31'd0, ip_valid}, 32'd0);
        tick();
        chk("len0_err_pulse", {31'd0, len_err}, 32'd0);
        repeat (4) tick();
        chk("len0_idle", {31'd0, busy}, 32'd0);

        // Reset mid-frame after 5 bytes; outputs clear without waiting for a clock.
        set_req(0, 1'b1, 8'd9, 16'd10);
        wait_grant(0, n);
        set_req(0, 1'b0, 8'h00, 16'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 8'h30 + 8'(i), 1'b0);
            tick();
        end
        chk("pre_rst_valid", {31'd0, ip_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, ip_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, ip_data}, 32'd0);
        chk("mid_rst_len", {16'd0, ip_len}, 32'd0);
        chk("mid_rst_type", {24'd0, ip_type}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        drive(0, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        set_req(1, 1'b1, 8'd1, 16'd2);
        wait_grant(1, n);
        set_req(1, 1'b0, 8'h00, 16'd0);
        stream(1, 2, 1, 8'h70, 2, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();

        // After a reset, simultaneous requests go to channel 0 first.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 8'd17, 16'd1);
        set_req(1, 1'b1, 8'd1, 16'd1);
        wait_grant(0, n);
        set_req(0, 1'b0, 8'h00, 16'd0);
        stream(0, 1, 0, 8'h90, 1, 1'b0, 1'b1, 1'b0);
        wait_grant(1, n);
        set_req(1, 1'b0, 8'h00, 16'd0);
        stream(1, 1, 0, 8'h91, 1, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef ARB_TIMEOUT_EN
        // 3 bytes, then a stall: 16 cycles later a 0x00 byte with last and error.
        set_req(0, 1'b1, 8'd17, 16'd10);
        wait_grant(0, n);
        set_req(0, 1'b0, 8'h00, 16'd0);
        stream(0, 3, -1, 8'h80, 3, 1'b0, 1'b0, 1'b0);
        repeat (15) tick();
        chk("to_quiet", {31'd0, ip_valid}, 32'd0);
        tick();
        chk("to_valid", {31'd0, ip_valid}, 32'd1);
        chk("to_data", {24'd0, ip_data}, 32'd0);
        chk("to_last", {31'd0, ip_last}, 32'd1);
        chk("to_err", {31'd0, len_err}, 32'd1);
        repeat (5) tick();
        chk("to_idle", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
